mitchell_dot_acc: RTL and testbench
===================================

Name: mitchell_dot_acc

Overview:
Downstream consumer of the Mitchell approximate multiplier. It accepts a stream of signed approximate products over a valid/ready handshake and accumulates a programmable number of them into a saturating signed dot-product. It then presents the result on a valid/ready output. It sits between the multiplier output and the result writeback in the approximate MAC datapath.

Parameters:
ACC_W, 24, accumulator/result width in bits, two's complement, minimum 18.
LEN_W, 8, width of the term-count field; max terms per run is 2^LEN_W-1.

Ports:
clk_i  input  1  clock, rising edge.
rst_i  input  1  synchronous reset, active-high.
start_i  input  1  begin a run; sampled only in IDLE.
len_i  input  LEN_W  number of terms in the run; sampled with start_i.
in_valid_i  input  1  product term valid.
in_ready_o  output  1  block accepts a term this cycle.
prod_i  input  16  multiplier product field. When sign_i=1 it holds the bitwise inverse of the magnitude, as the multiplier emits it.
sign_i  input  1  product sign (x[8]^y[8]).
out_valid_o  output  1  result valid.
out_ready_i  input  1  downstream accepts the result.
acc_o  output  ACC_W  accumulated signed result.
ovf_o  output  1  sticky saturation flag for the current run.
busy_o  output  1  high in ACCUM or DONE.

Behaviour:
- Clock and reset: one clock domain. rst_i is synchronous and active-high. Reset forces state to IDLE and clears all outputs and registers: in_ready_o=0, out_valid_o=0, acc_o=0, ovf_o=0, busy_o=0, counter=0.
- Reset mid-run: the partial run is discarded. No result is emitted.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - start_i=1 latches len_i into the down-counter, clears the accumulator and clears ovf_o.
  - If len_i!=0, next state is ACCUM. If len_i==0, next state is DONE with acc_o=0.
- ACCUM:
  - in_ready_o=1 combinationally.
  - A term is accepted when in_valid_i & in_ready_o. Each accepted term updates the accumulator on that edge and decrements the counter.
  - When the counter is 1 and a term is accepted, next state is DONE.
  - Idle cycles (in_valid_i=0) hold all state.
- DONE:
  - out_valid_o=1 and in_ready_o=0. acc_o and ovf_o are held stable while out_valid_o=1 and out_ready_i=0.
  - On out_valid_o & out_ready_i, next state is IDLE. out_valid_o drops the next cycle. acc_o retains its value until the next start.
- start_i is ignored outside IDLE. It is never queued.
- Term conversion:
  - sign_i=0: term = +{0,prod_i}.
  - sign_i=1: term = -(~prod_i), i.e. prod_i zero-extended to 17 bits, minus 2^16, plus 1.
  - The 17-bit signed term is sign-extended to ACC_W+1.
- Saturating add:
  - sum = acc + term, computed at ACC_W+1 bits.
  - If sum > 2^(ACC_W-1)-1, acc = 2^(ACC_W-1)-1 and ovf_o=1.
  - If sum < -2^(ACC_W-1), acc = -2^(ACC_W-1) and ovf_o=1.
  - Otherwise acc = sum.
  - ovf_o is sticky until the next start or reset. Saturation does not change the term count.
- Latency: out_valid_o asserts the cycle after the last term's handshake edge. Throughput is one term per clock.
- acc_o is a registered output. It shows the running sum during ACCUM; downstream qualifies it with out_valid_o.
- busy_o = (state != IDLE).

Test Plan:
- Basic signed sum, ACC_W=24. start_i, len_i=3. Terms (prod_i=100,sign_i=0), (200,0), (16'hFED3,1) [magnitude 300]. Required: out_valid_o=1 exactly one cycle after the third handshake, acc_o=0, ovf_o=0. out_ready_i=1 returns the block to IDLE the next cycle.
- Gaps and backpressure. len_i=2. in_valid_i toggled 1,0,0,1 with prod_i=5 then 7, sign 0. Then hold out_ready_i=0 for 4 cycles. Required: acc_o=12 held stable with out_valid_o=1 for all 4 cycles. in_ready_o=0 in DONE. A start_i pulse during DONE is ignored.
- Saturation with ACC_W=18. len_i=3, three terms (65535,0). Required: acc_o=131071, ovf_o=1. A following run with start_i and len_i=1, term (1,0), gives acc_o=1 and ovf_o=0.
- Negative saturation with ACC_W=18. len_i=3, three terms (16'h0000,1) [magnitude 65535]. Required: acc_o=-131072 (18'h20000), ovf_o=1.
- Zero-length run. start_i with len_i=0. Required: in_ready_o stays 0, out_valid_o=1 the next cycle, acc_o=0, ovf_o=0.
- Reset mid-run. len_i=4, accept 2 terms of (10,0), assert rst_i for one cycle. Required on the following cycle: state IDLE, acc_o=0, busy_o=0, out_valid_o=0. No result is emitted, and further in_valid_i is not accepted.

Source files
------------

// File: rtl/mitchell_dot_acc.sv
// rtl/mitchell_dot_acc.sv - saturating signed dot-product accumulator for Mitchell products
//
// Accumulates len_i signed approximate products into a saturating ACC_W-bit
// two's complement result and presents it over a valid/ready output.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset
//   start_i      begin a run (IDLE only), len_i sampled with it
//   len_i        number of terms in the run (0 gives an immediate zero result)
//   in_valid_i   product term valid
//   in_ready_o   term accepted this cycle when in_valid_i is also high
//   prod_i       product field; holds ~magnitude when sign_i=1
//   sign_i       product sign
//   out_valid_o  result valid
//   out_ready_i  downstream accepts the result
//   acc_o        accumulated signed result (running sum during ACCUM)
//   ovf_o        sticky saturation flag for the current run
//   busy_o       high while a run is in progress or awaiting handoff
module mitchell_dot_acc #(
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [15:0]      prod_i,
    input  logic             sign_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [ACC_W-1:0] acc_o,
    output logic             ovf_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [LEN_W-1:0] cnt_q;
    logic [ACC_W-1:0] acc_q;
    logic             ovf_q;

    logic [16:0]      term;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] acc_d;
    logic             sat_d;

    // The multiplier hands over ~magnitude for negative products, so the
    // signed term is -(~prod_i); a 17-bit field covers -65535..65535.
    always_comb begin
        term = {1'b0, prod_i};
        if (sign_i) begin
            term = 17'd0 - {1'b0, ~prod_i};
        end
    end

    // One guard bit is enough: a 17-bit term cannot push an ACC_W+1 sum
    // past its own range when ACC_W >= 18.
    assign sum = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-16){term[16]}}, term};

    // Guard bit disagreeing with the result MSB means the ACC_W-bit range
    // was left; the guard bit tells which rail to clamp to.
    always_comb begin
        acc_d = sum[ACC_W-1:0];
        sat_d = 1'b0;
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            sat_d = 1'b1;
            acc_d = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        cnt_q   <= len_i;
                        acc_q   <= '0;
                        ovf_q   <= 1'b0;
                        state_q <= (len_i == '0) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid_i) begin
                        acc_q <= acc_d;
                        ovf_q <= ovf_q | sat_d;
                        cnt_q <= cnt_q - LEN_W'(1);
                        if (cnt_q == LEN_W'(1)) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready_o  = (state_q == ACCUM);
    assign out_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign acc_o       = acc_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_mitchell_dot_acc.sv
// tb/tb_mitchell_dot_acc.sv - self-checking bench for mitchell_dot_acc at ACC_W=24 and ACC_W=18
module tb_mitchell_dot_acc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  len = '0;
    logic        in_valid = 1'b0;
    logic [15:0] prod = '0;
    logic        sign = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready_a, out_valid_a, ovf_a, busy_a;
    logic [23:0] acc_a;
    logic        in_ready_b, out_valid_b, ovf_b, busy_b;
    logic [17:0] acc_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mitchell_dot_acc #(.ACC_W(24), .LEN_W(8)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len),
        .in_valid_i(in_valid), .in_ready_o(in_ready_a), .prod_i(prod), .sign_i(sign),
        .out_valid_o(out_valid_a), .out_ready_i(out_ready), .acc_o(acc_a),
        .ovf_o(ovf_a), .busy_o(busy_a)
    );

    mitchell_dot_acc #(.ACC_W(18), .LEN_W(8)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len),
        .in_valid_i(in_valid), .in_ready_o(in_ready_b), .prod_i(prod), .sign_i(sign),
        .out_valid_o(out_valid_b), .out_ready_i(out_ready), .acc_o(acc_b),
        .ovf_o(ovf_b), .busy_o(busy_b)
    );

    typedef struct {
        int               n;
        logic [7:0][15:0] p;
        logic [7:0]       s;
        longint           e24;
        logic             o24;
        longint           e18;
        logic             o18;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer sum of signed products, clamped to the
    // width's two's complement range after every term.
    function automatic longint term_of(input logic [15:0] p, input logic s);
        logic [15:0] m;
        m = ~p;
        return s ? -longint'(m) : longint'(p);
    endfunction

    function automatic void model(input int n, input logic [7:0][15:0] p, input logic [7:0] s,
                                  input int w, output longint e, output logic o);
        longint hi, lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
        e = 0;
        o = 1'b0;
        for (int i = 0; i < n; i++) begin
            e = e + term_of(p[i], s[i]);
            if (e > hi) begin e = hi; o = 1'b1; end
            else if (e < lo) begin e = lo; o = 1'b1; end
        end
    endfunction

    function automatic vec_t mk(input int n, input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] c, input logic [15:0] d, input logic [3:0] sg,
                                input longint e24, input logic o24, input longint e18, input logic o18);
        vec_t v;
        v.n = n;
        v.p = '0;
        v.p[0] = a; v.p[1] = b; v.p[2] = c; v.p[3] = d;
        v.s = {4'b0, sg};
        v.e24 = e24; v.o24 = o24; v.e18 = e18; v.o18 = o18;
        return v;
    endfunction

    task automatic chk_result(input string tag, input longint e24, input logic o24,
                              input longint e18, input logic o18);
        chk({tag, " acc24"}, longint'($signed(acc_a)), e24);
        chk({tag, " ovf24"}, longint'(ovf_a), longint'(o24));
        chk({tag, " acc18"}, longint'($signed(acc_b)), e18);
        chk({tag, " ovf18"}, longint'(ovf_b), longint'(o18));
    endtask

    // Full run from IDLE: start, feed n terms (optionally with gaps), check the
    // result appears exactly one cycle after the last handshake, stall the
    // handoff rdy_wait cycles, then release and check return to IDLE.
    task automatic do_run(input string tag, input int n, input logic [7:0][15:0] p,
                          input logic [7:0] s, input bit gaps, input int rdy_wait,
                          input longint e24, input logic o24, input longint e18, input logic o18);
        int budget;
        start = 1'b1;
        len = 8'(n);
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
            end
            in_valid = 1'b1;
            prod = p[i];
            sign = s[i];
            budget = 0;
            while (!(in_ready_a && in_ready_b) && budget < 20) begin
                tick();
                budget++;
            end
            if (budget >= 20) chk({tag, " in_ready timeout"}, 0, 1);
            tick();
            in_valid = 1'b0;
            prod = 16'($urandom);
        end
        chk({tag, " out_valid latency"}, longint'({out_valid_a, out_valid_b}), 3);
        chk({tag, " in_ready in DONE"}, longint'({in_ready_a, in_ready_b}), 0);
        chk_result(tag, e24, o24, e18, o18);
        repeat (rdy_wait) tick();
        if (rdy_wait > 0) begin
            chk({tag, " held valid"}, longint'({out_valid_a, out_valid_b}), 3);
            chk_result({tag, " held"}, e24, o24, e18, o18);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, " back to idle"}, longint'({out_valid_a, out_valid_b, busy_a, busy_b}), 0);
        chk({tag, " acc retained"}, longint'($signed(acc_a)), e24);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint e24, e18;
        logic o24, o18;
        logic [7:0][15:0] rp;
        logic [7:0] rs;
        int rn;

        tbl[0] = mk(3, 16'd100, 16'd200, 16'hFED3, 16'd0, 4'b0100, 0, 0, 0, 0);
        tbl[1] = mk(2, 16'd5, 16'd7, 16'd0, 16'd0, 4'b0000, 12, 0, 12, 0);
        tbl[2] = mk(3, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd0, 4'b0000, 196605, 0, 131071, 1);
        tbl[3] = mk(1, 16'd1, 16'd0, 16'd0, 16'd0, 4'b0000, 1, 0, 1, 0);
        tbl[4] = mk(3, 16'h0000, 16'h0000, 16'h0000, 16'd0, 4'b0111, -196605, 0, -131072, 1);
        tbl[5] = mk(4, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b1000, 131070, 0, 65536, 1);
        tbl[6] = mk(0, 16'd0, 16'd0, 16'd0, 16'd0, 4'b0000, 0, 0, 0, 0);
        tbl[7] = mk(2, 16'h8000, 16'h7FFF, 16'd0, 16'd0, 4'b0010, 0, 0, 0, 0);

        repeat (2) tick();
        chk("reset outputs", longint'({in_ready_a, out_valid_a, ovf_a, busy_a,
                                        in_ready_b, out_valid_b, ovf_b, busy_b}), 0);
        chk("reset acc", longint'({acc_a, acc_b}), 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            do_run($sformatf("vec%0d", i), tbl[i].n, tbl[i].p, tbl[i].s, 1'b0, i % 3,
                   tbl[i].e24, tbl[i].o24, tbl[i].e18, tbl[i].o18);
        end

        // Zero length: no term is ever requested.
        start = 1'b1; len = 8'd0;
        tick();
        start = 1'b0;
        chk("zero len in_ready", longint'({in_ready_a, in_ready_b}), 0);
        chk("zero len out_valid", longint'({out_valid_a, out_valid_b}), 3);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // Gaps, backpressure and an ignored start during DONE.
        start = 1'b1; len = 8'd2;
        tick();
        start = 1'b0;
        in_valid = 1'b1; prod = 16'd5; sign = 1'b0; tick();
        in_valid = 1'b0; tick(); tick();
        chk("gap hold acc", longint'($signed(acc_a)), 5);
        in_valid = 1'b1; prod = 16'd7; tick();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            start = (k == 1);
            len = 8'd9;
            chk($sformatf("bp%0d valid", k), longint'({out_valid_a, out_valid_b, in_ready_a, in_ready_b}), 12);
            chk($sformatf("bp%0d acc", k), longint'($signed(acc_a)) + longint'($signed(acc_b)), 24);
            tick();
        end
        start = 1'b0;
        chk("bp after start", longint'({out_valid_a, busy_a}), 3);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("bp idle", longint'({out_valid_a, busy_a, out_valid_b, busy_b}), 0);
        chk("bp acc retained", longint'($signed(acc_b)), 12);

        // Reset mid-run discards the partial sum.
        start = 1'b1; len = 8'd4;
        tick();
        start = 1'b0;
        in_valid = 1'b1; prod = 16'd10; sign = 1'b0;
        tick(); tick();
        chk("pre-reset acc", longint'($signed(acc_a)), 20);
        rst = 1'b1; tick(); rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("post-reset%0d", k), longint'({busy_a, out_valid_a, in_ready_a,
                                                         busy_b, out_valid_b, in_ready_b}), 0);
            chk($sformatf("post-reset%0d acc", k), longint'({acc_a, acc_b}), 0);
            tick();
        end
        in_valid = 1'b0;

        // Randomized runs against the model.
        for (int r = 0; r < 30; r++) begin
            rn = $urandom_range(1, 8);
            for (int i = 0; i < 8; i++) begin
                rp[i] = 16'($urandom);
                rs[i] = 1'($urandom);
            end
            if (r % 5 == 0) rs = '0;
            model(rn, rp, rs, 24, e24, o24);
            model(rn, rp, rs, 18, e18, o18);
            do_run($sformatf("rnd%0d", r), rn, rp, rs, 1'b1, $urandom_range(0, 3), e24, o24, e18, o18);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
